seq_pipe_delay_elastic: RTL
===========================

SEQ_PIPE_DELAY_ELASTIC -- requirements
Module: seq_pipe_delay_elastic

Interface
REQ-001 Parameter NBITS, default 8, data width in bits (SHALL be >= 1).
REQ-002 Parameter NSTAGES, default 4, number of register stages (SHALL be >= 1).
REQ-003 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous pipeline clear.
REQ-006 in_val  input  1  producer has valid data on in_.
REQ-007 in_rdy  output  1  block accepts in_ this cycle.
REQ-008 in_  input  NBITS  input data.
REQ-009 out_val  output  1  out holds valid data.
REQ-010 out_rdy  input  1  consumer accepts out this cycle.
REQ-011 out  output  NBITS  output data.
REQ-012 count  output  $clog2(NSTAGES+1)  number of occupied stages.

Function
REQ-013 Each stage i (0..NSTAGES-1) SHALL hold one data register and one valid bit; stage 0 is fed from in_, stage NSTAGES-1 drives out.
REQ-014 Transfer SHALL occur on an interface only on a posedge where its val and rdy are both 1.
REQ-015 Stage i SHALL be ready when its valid bit is 0 or stage i+1 (or the output interface, for the last stage) takes its data that cycle.
REQ-016 in_rdy SHALL equal stage 0 ready AND NOT flush; this ready chain from out_rdy is combinational.
REQ-017 Empty stages SHALL absorb data even when downstream is stalled (bubble collapse).
REQ-018 With no stalls, a word accepted at edge k SHALL appear with out_val=1 after edge k+NSTAGES-1, i.e. latency NSTAGES cycles; NSTAGES=1 reproduces a one-cycle delay register.
REQ-019 Sustained throughput SHALL be one word per cycle when out_rdy=1 continuously.
REQ-020 Word order SHALL be preserved; no word SHALL be duplicated or dropped except by flush or reset.
REQ-021 out_val SHALL equal last-stage valid AND NOT flush; out SHALL be 0 when out_val=0.
REQ-022 A stage whose data does not advance and which receives no new data SHALL hold its data and valid bit unchanged.
REQ-023 flush=1 at a posedge SHALL clear all valid bits; no input or output transfer occurs in that cycle.
REQ-024 count SHALL be a register equal to the number of set valid bits after each edge: +1 on input-only transfer, -1 on output-only, unchanged when both or neither, 0 after flush.
REQ-025 When count=NSTAGES and out_rdy=0, in_rdy SHALL be 0; when full and out_rdy=1, in_rdy SHALL be 1 (simultaneous enqueue/dequeue).

Reset
REQ-026 reset_n=0 SHALL immediately clear all valid bits and count to 0, forcing out_val=0, out=0, in_rdy=1 (when flush=0).
REQ-027 Data registers SHALL NOT be reset.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight words; the first word accepted after deassertion SHALL be the first word out.

Structure
REQ-029 No shared package typedefs are required; count width SHALL be a local parameter derived from NSTAGES.
REQ-030 One sub-module, seq_pipe_stage (data reg + valid bit + local ready), SHALL be instantiated NSTAGES times via generate.

Verification (NSTAGES=4, NBITS=8)
REQ-031 Reset then stream 0x01..0x08 with out_rdy=1 -> out_val first rises 4 cycles after 0x01 accepted; 0x01..0x08 out on consecutive cycles; count peaks at 4.
REQ-032 Fill with 0xA0..0xA3, out_rdy=0 -> count=4, in_rdy=0, out=0xA0 held; raise out_rdy -> 0xA0..0xA3 drained in order, one per cycle.
REQ-033 Full, out_rdy=1, in_val=1 with 0x55 -> in_rdy=1, count stays 4, 0x55 emerges after 0xA3.
REQ-034 Two words in flight, out_rdy=0, then flush=1 one cycle -> in_rdy=0 and out_val=0 during flush; afterwards count=0, out_val=0, out=0.
REQ-035 Stream 0x10..0x13, assert reset_n=0 mid-cycle -> out_val and count drop to 0 without a clock edge; after release, input 0x77 is the next word out.
REQ-036 Random in_val/out_rdy for 1000 cycles against a FIFO scoreboard -> output order and count match exactly.

Source files
------------

// File: rtl/seq_pipe_delay_elastic_pkg.sv
// rtl/seq_pipe_delay_elastic_pkg.sv - shared helpers for the elastic delay pipeline
package seq_pipe_delay_elastic_pkg;

  // A handshake transfer happens only when both sides agree in the same cycle.
  function automatic logic fire(input logic val, input logic rdy);
    return val & rdy;
  endfunction

endpackage

// File: rtl/seq_pipe_delay_elastic_stage.sv
// rtl/seq_pipe_delay_elastic_stage.sv - one elastic stage: data reg, valid bit, local ready
module seq_pipe_stage
  import seq_pipe_delay_elastic_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [NBITS-1:0] up_data,
  input  logic             dn_ready,
  output logic             ready,
  output logic             valid,
  output logic [NBITS-1:0] data
);

  logic             valid_q, valid_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             load;

  // Ready when empty or when the occupant leaves this cycle; an empty stage
  // always absorbs, which is what collapses bubbles behind a stall.
  always_comb begin
    ready   = !valid_q || dn_ready;
    load    = fire(up_valid, ready) && !flush;
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ready) begin
      valid_d = up_valid;
    end
    if (load) begin
      data_d = up_data;
    end
  end

  // Valid bit is the only state that reset has to clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data is qualified by valid, so it is left unreset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/seq_pipe_delay_elastic.sv
// rtl/seq_pipe_delay_elastic.sv - NSTAGES-deep elastic delay pipeline with occupancy count
module seq_pipe_delay_elastic
  import seq_pipe_delay_elastic_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int NSTAGES = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [NBITS-1:0]             in_,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [NBITS-1:0]             out,
  output logic [$clog2(NSTAGES+1)-1:0] count
);

  localparam int CW = $clog2(NSTAGES + 1);

  logic [NSTAGES-1:0] st_valid;
  logic [NSTAGES-1:0] st_ready;
  logic [NSTAGES-1:0] up_valid;
  logic [NSTAGES-1:0] dn_ready;
  logic [NBITS-1:0]   st_data [NSTAGES];
  logic [NBITS-1:0]   up_data [NSTAGES];

  logic          in_fire;
  logic          out_fire;
  logic [CW-1:0] count_q, count_d;

  for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_valid[i] = in_val;
      assign up_data[i]  = in_;
    end else begin : g_link
      assign up_valid[i] = st_valid[i-1];
      assign up_data[i]  = st_data[i-1];
    end

    if (i == NSTAGES - 1) begin : g_tail
      assign dn_ready[i] = out_rdy;
    end else begin : g_mid
      assign dn_ready[i] = st_ready[i+1];
    end

    seq_pipe_stage #(
      .NBITS(NBITS)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .up_valid(up_valid[i]),
      .up_data (up_data[i]),
      .dn_ready(dn_ready[i]),
      .ready   (st_ready[i]),
      .valid   (st_valid[i]),
      .data    (st_data[i])
    );
  end

  // Flush blocks both interfaces; output data is zeroed whenever it is not valid.
  always_comb begin
    in_rdy   = st_ready[0] && !flush;
    out_val  = st_valid[NSTAGES-1] && !flush;
    out      = out_val ? st_data[NSTAGES-1] : '0;
    in_fire  = fire(in_val, in_rdy);
    out_fire = fire(out_val, out_rdy);
  end

  // Occupancy tracks accepted minus delivered words; flush empties the pipe.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_fire && !out_fire) begin
      count_d = count_q + CW'(1);
    end else if (out_fire && !in_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
